t01_vga_scan_ctrl: RTL and testbench



---
 rtl/t01_vga_pkg.sv | 57 +++++
 rtl/t01_vga_pixel_tick.sv | 38 +++
 rtl/t01_vga_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_t01_vga_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/t01_vga_pkg.sv
// t01_vga_pkg
//   Shared definitions for the 640x480@60 Hz VGA scan controller.
//   - Default timing values (pixels / lines) and the derived 10-bit totals
//     and sync window bounds for the standard mode.
//   - phase_e: the four raster phases used on both axes.
//   - Colour constants for the 3-bit {R,G,B} pin bus.
//   - phase_of(): maps a counter value onto its raster phase.
package t01_vga_pkg;

   // Standard 640x480@60 Hz timing
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FRONT  = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BACK   = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FRONT  = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BACK   = 33;
   localparam int unsigned DEF_CLK_DIV  = 2;

   localparam logic [9:0] H_TOTAL      = 10'd800;
   localparam logic [9:0] V_TOTAL      = 10'd525;
   // Sync windows are [START, END): END is the first count after the pulse
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd752;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd492;

   typedef enum logic [1:0] {
      ACT  = 2'd0,
      FP   = 2'd1,
      SYNC = 2'd2,
      BP   = 2'd3
   } phase_e;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] RED   = 3'b100;

   // The phase is a pure function of the count, so a corrupted phase
   // register is overwritten on the next update instead of locking up.
   function automatic phase_e phase_of(input logic [9:0] cnt,
                                       input logic [9:0] act_end,
                                       input logic [9:0] fp_end,
                                       input logic [9:0] sync_end);
      if (cnt < act_end) begin
         return ACT;
      end else if (cnt < fp_end) begin
         return FP;
      end else if (cnt < sync_end) begin
         return SYNC;
      end else begin
         return BP;
      end
   endfunction

endpackage

// File: rtl/t01_vga_pixel_tick.sv
// t01_vga_pixel_tick
//   Divides the system clock down to the pixel rate. The divider counts
//   0..CLK_DIV-1 and tick is high for the clk cycle in which it sits at
//   CLK_DIV-1. With CLK_DIV=1 tick is permanently high.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous, active-high reset (divider returns to 0)
//   tick out  one-clk pixel enable
module t01_vga_pixel_tick
   import t01_vga_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/t01_vga_scan_ctrl.sv
// t01_vga_scan_ctrl
//   Raster scan generator and registered pixel output stage for VGA.
//   x/y drive the combinational shape renderers; their shape_color is
//   sampled on the same pixel tick and registered to the pins together
//   with the syncs, so the pins lag x/y by exactly one pixel tick.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   shape_color  in   {R,G,B} from the renderers for the current x/y
//   x, y         out  current scan position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   active       out  registered, high while the pins carry a visible pixel
//   hsync, vsync out  registered, active-low
//   rgb          out  registered {R,G,B}, forced to black while blanking
//   frame_start  out  one-clk pulse when the scan wraps to (0,0)
// Build option:
//   T01_VGA_BORDER_EN  when defined, the outermost visible rows and columns
//                      are drawn white regardless of shape_color.
module t01_vga_scan_ctrl
   import t01_vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT  = DEF_H_FRONT,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BACK   = DEF_H_BACK,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT  = DEF_V_FRONT,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BACK   = DEF_V_BACK,
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] shape_color,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb,
   output logic       frame_start
);

   // Phase boundaries as 10-bit values; *_LAST is TOTAL-1, the wrap point
   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
   localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] H_SYNC_E   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] V_SYNC_E   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
`ifdef T01_VGA_BORDER_EN
   localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
`endif

   logic tick;

   t01_vga_pixel_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   phase_e     h_phase_q, h_phase_d;
   phase_e     v_phase_q, v_phase_d;
   logic       active_q, active_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic [2:0] rgb_q, rgb_d;
   logic       frame_start_q, frame_start_d;

   logic       active_now;
   logic [2:0] pix_color;

   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      active_d      = active_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;

      active_now = (h_phase_q == ACT) && (v_phase_q == ACT);

`ifdef T01_VGA_BORDER_EN
      if ((x_q == 10'd0) || (x_q == H_ACT_LAST) ||
          (y_q == 10'd0) || (y_q == V_ACT_LAST)) begin
         pix_color = WHITE;
      end else begin
         pix_color = shape_color;
      end
`else
      pix_color = shape_color;
`endif

      if (tick) begin
         if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
               y_d           = 10'd0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end

         // Output stage samples the pre-increment position, giving the
         // one-tick pin latency with colour and syncs aligned.
         active_d = active_now;
         rgb_d    = active_now ? pix_color : BLACK;
         hsync_d  = (h_phase_q != SYNC);
         vsync_d  = (v_phase_q != SYNC);
      end

      // Phase tracks the next count so it always matches x_q/y_q
      h_phase_d = phase_of(x_d, H_ACT_END, H_FP_END, H_SYNC_E);
      v_phase_d = phase_of(y_d, V_ACT_END, V_FP_END, V_SYNC_E);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         h_phase_q     <= ACT;
         v_phase_q     <= ACT;
         active_q      <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= BLACK;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         h_phase_q     <= h_phase_d;
         v_phase_q     <= v_phase_d;
         active_q      <= active_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign active      = active_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_t01_vga_scan_ctrl.sv
// Testbench for t01_vga_scan_ctrl.
// u_dut uses a shrunken raster (25x11, CLK_DIV=2) so whole frames fit in a
// short run; u_full uses the standard 640x480 timing for one full line.
module tb_t01_vga_scan_ctrl;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;   // 25 pixels per line
   localparam int VA = 6,  VF = 1, VS = 2, VB = 2;   // 11 lines per frame
   localparam int CD = 2;
   localparam int FRAME_CLKS = (HA + HF + HS + HB) * (VA + VF + VS + VB) * CD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst_f = 1'b1;
   int         mode = 0;
   logic [2:0] const_col = 3'b000;

   logic [9:0] x, y;
   logic       active, hsync, vsync, frame_start;
   logic [2:0] rgb, shape_color;

   logic [9:0] xf, yf;
   logic       active_f, hsync_f, vsync_f, frame_start_f;
   logic [2:0] rgb_f;
   logic [2:0] shape_color_f;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [2:0] pat(input int px, input int py);
      return {px[0], py[0], px[1] ^ py[1]};
   endfunction

   // Renderer stand-in: a function of the current scan position
   assign shape_color   = (mode == 1) ? pat(int'(x), int'(y)) : const_col;
   assign shape_color_f = 3'b100;

   t01_vga_scan_ctrl #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .CLK_DIV  (CD)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .shape_color (shape_color),
      .x           (x),
      .y           (y),
      .active      (active),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .frame_start (frame_start)
   );

   t01_vga_scan_ctrl u_full (
      .clk         (clk),
      .rst         (rst_f),
      .shape_color (shape_color_f),
      .x           (xf),
      .y           (yf),
      .active      (active_f),
      .hsync       (hsync_f),
      .vsync       (vsync_f),
      .rgb         (rgb_f),
      .frame_start (frame_start_f)
   );

   // Expected pins kk clk edges after reset release:
   // {x, y, active, hsync, vsync, rgb, frame_start}
   function automatic logic [26:0] model(input int kk, input int cd,
                                         input int ha, input int hf, input int hs, input int hb,
                                         input int va, input int vf, input int vs, input int vb,
                                         input int md, input logic [2:0] cc);
      int ht, vt, t, p, px, py;
      logic [9:0] ex, ey;
      logic act, hsn, vsn, fs;
      logic [2:0] col;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      t  = kk / cd;
      ex = 10'(t % ht);
      ey = 10'((t / ht) % vt);
      fs = (t > 0) && (kk % cd == 0) && (t % (ht * vt) == 0);
      if (t == 0) begin
         act = 1'b0; hsn = 1'b1; vsn = 1'b1; col = 3'b000;
      end else begin
         p   = t - 1;
         px  = p % ht;
         py  = (p / ht) % vt;
         act = (px < ha) && (py < va);
         hsn = !((px >= ha + hf) && (px < ha + hf + hs));
         vsn = !((py >= va + vf) && (py < va + vf + vs));
         col = (md == 1) ? pat(px, py) : cc;
`ifdef T01_VGA_BORDER_EN
         if (px == 0 || px == ha - 1 || py == 0 || py == va - 1) col = 3'b111;
`endif
         if (!act) col = 3'b000;
      end
      return {ex, ey, act, hsn, vsn, col, fs};
   endfunction

   task automatic edge_clk();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic restart_small();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [26:0] got;
      rst = 1'b1;
      mode = 0;
      const_col = 3'b100;
      repeat (3) @(negedge clk);
      got = {x, y, active, hsync, vsync, rgb, frame_start};
      n_cmp++; if (x !== 10'd0)        begin n_bad++; $display("FAIL reset_x got=%0d exp=0", x); end
      n_cmp++; if (y !== 10'd0)        begin n_bad++; $display("FAIL reset_y got=%0d exp=0", y); end
      n_cmp++; if (active !== 1'b0)    begin n_bad++; $display("FAIL reset_active got=%b exp=0", active); end
      n_cmp++; if (hsync !== 1'b1)     begin n_bad++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
      n_cmp++; if (vsync !== 1'b1)     begin n_bad++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
      n_cmp++; if (rgb !== 3'b000)     begin n_bad++; $display("FAIL reset_rgb got=%b exp=000", rgb); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got=%b exp=0 (all=%h)", frame_start, got); end
      rst = 1'b0;
      edge_clk();   // divider 0 -> 1, no tick consumed yet
      n_cmp++; if (x !== 10'd0) begin n_bad++; $display("FAIL first_edge_x got=%0d exp=0", x); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL release_fs got=%b exp=0", frame_start); end
      edge_clk();   // first tick consumed: pins now show pixel (0,0)
      n_cmp++; if (x !== 10'd1) begin n_bad++; $display("FAIL first_tick_x got=%0d exp=1", x); end
      n_cmp++; if ({active, hsync, vsync, rgb} !== 6'b111_100)
         begin n_bad++; $display("FAIL first_pixel_pins got=%b exp=111100", {active, hsync, vsync, rgb}); end
   endtask

   // Continues from test_reset (2 edges after release) with colour RED
   task automatic test_frame_red();
      logic [26:0] got, exp;
      int hs_low, hs_first, vs_low, fs_cnt, fs_last, fs_gap;
      hs_low = 0; hs_first = -1; vs_low = 0; fs_cnt = 0; fs_last = -1; fs_gap = -1;
      for (int kk = 3; kk <= 2 * FRAME_CLKS + 4; kk++) begin
         edge_clk();
         got = {x, y, active, hsync, vsync, rgb, frame_start};
         exp = model(kk, CD, HA, HF, HS, HB, VA, VF, VS, VB, 0, 3'b100);
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL frame_red k=%0d got=%h exp=%h", kk, got, exp);
         end
         if (kk <= 2 * 25 + 1) begin
            if (kk % 2 == 0 && hsync === 1'b0) hs_low++;
            if (hsync === 1'b0 && hs_first < 0) hs_first = kk;
         end
         if (kk <= FRAME_CLKS && vsync === 1'b0) vs_low++;
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_last >= 0) fs_gap = kk - fs_last;
            fs_last = kk;
         end
      end
      // Sync pulse starts the tick after x==18 (tick 19 -> edge 38)
      n_cmp++; if (hs_low !== 4)     begin n_bad++; $display("FAIL hsync_width got=%0d exp=4", hs_low); end
      n_cmp++; if (hs_first !== 38)  begin n_bad++; $display("FAIL hsync_start got=%0d exp=38", hs_first); end
      n_cmp++; if (vs_low !== 100)   begin n_bad++; $display("FAIL vsync_clks got=%0d exp=100", vs_low); end
      n_cmp++; if (fs_cnt !== 2)     begin n_bad++; $display("FAIL fs_count got=%0d exp=2", fs_cnt); end
      n_cmp++; if (fs_gap !== 550)   begin n_bad++; $display("FAIL fs_period got=%0d exp=550", fs_gap); end
   endtask

   task automatic test_pattern();
      logic [26:0] got, exp;
      mode = 1;
      restart_small();
      for (int kk = 1; kk <= FRAME_CLKS + 50; kk++) begin
         edge_clk();
         got = {x, y, active, hsync, vsync, rgb, frame_start};
         exp = model(kk, CD, HA, HF, HS, HB, VA, VF, VS, VB, 1, 3'b000);
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL pattern k=%0d got=%h exp=%h", kk, got, exp);
         end
      end
   endtask

   task automatic test_border_black();
      logic [26:0] got, exp;
      int white, white_exp;
      mode = 0;
      const_col = 3'b000;
      white = 0;
`ifdef T01_VGA_BORDER_EN
      white_exp = 80;   // 40 border pixels of a 16x6 area, 2 clks each
`else
      white_exp = 0;
`endif
      restart_small();
      for (int kk = 1; kk <= FRAME_CLKS + 1; kk++) begin
         edge_clk();
         got = {x, y, active, hsync, vsync, rgb, frame_start};
         exp = model(kk, CD, HA, HF, HS, HB, VA, VF, VS, VB, 0, 3'b000);
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL border k=%0d got=%h exp=%h", kk, got, exp);
         end
         if (rgb === 3'b111) white++;
      end
      n_cmp++; if (white !== white_exp) begin n_bad++; $display("FAIL border_count got=%0d exp=%0d", white, white_exp); end
   endtask

   task automatic test_reset_mid_sync();
      logic [26:0] got, exp;
      mode = 0;
      const_col = 3'b100;
      restart_small();
      // Tick 195 -> scan at (20,7); pins show pixel (19,7), inside both syncs
      repeat (390) edge_clk();
      n_cmp++; if (x !== 10'd20 || y !== 10'd7) begin n_bad++; $display("FAIL midsync_pos got=%0d,%0d exp=20,7", x, y); end
      n_cmp++; if (hsync !== 1'b0) begin n_bad++; $display("FAIL midsync_hsync got=%b exp=0", hsync); end
      n_cmp++; if (vsync !== 1'b0) begin n_bad++; $display("FAIL midsync_vsync got=%b exp=0", vsync); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({hsync, vsync, rgb, active} !== 6'b11_000_0)
         begin n_bad++; $display("FAIL async_rst_pins got=%b exp=110000", {hsync, vsync, rgb, active}); end
      n_cmp++; if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b0)
         begin n_bad++; $display("FAIL async_rst_pos got=%0d,%0d,%b exp=0,0,0", x, y, frame_start); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int kk = 1; kk <= 60; kk++) begin
         edge_clk();
         got = {x, y, active, hsync, vsync, rgb, frame_start};
         exp = model(kk, CD, HA, HF, HS, HB, VA, VF, VS, VB, 0, 3'b100);
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL restart k=%0d got=%h exp=%h", kk, got, exp);
         end
      end
   endtask

   task automatic test_default_timing();
      logic [26:0] got, exp;
      int hs_low;
      hs_low = 0;
      @(negedge clk);
      rst_f = 1'b0;
      for (int kk = 1; kk <= 2 * 800 + 40; kk++) begin
         edge_clk();
         got = {xf, yf, active_f, hsync_f, vsync_f, rgb_f, frame_start_f};
         exp = model(kk, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 3'b100);
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL std_line k=%0d got=%h exp=%h", kk, got, exp);
         end
         if (kk <= 1601 && hsync_f === 1'b0) hs_low++;
         if (kk == 2 * 657 - 1) begin
            n_cmp++; if (hsync_f !== 1'b1) begin n_bad++; $display("FAIL std_hs_pre got=%b exp=1", hsync_f); end
         end
         if (kk == 2 * 657) begin
            n_cmp++; if (hsync_f !== 1'b0) begin n_bad++; $display("FAIL std_hs_start got=%b exp=0", hsync_f); end
         end
      end
      n_cmp++; if (hs_low !== 192) begin n_bad++; $display("FAIL std_hs_clks got=%0d exp=192", hs_low); end
   endtask

   initial begin
      test_reset();
      test_frame_red();
      test_pattern();
      test_border_black();
      test_reset_mid_sync();
      test_default_timing();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
